// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, address-mux encodings, sequencer states and opcode-class helpers
package lc3_pkg;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic A1_PC  = 1'b0;
  localparam logic A1_SR1 = 1'b1;
  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;
  typedef enum logic [2:0] {IDLE, ADDR, IRD, IMAR, ACC, WB, DONE, ERR} state_t;
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_LD, OP_ST, OP_LDR, OP_STR, OP_LDI, OP_STI, OP_LEA};
  endfunction
  function automatic logic is_base(input logic [3:0] op);
    return op inside {OP_LDR, OP_STR};
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction
  function automatic logic is_ind(input logic [3:0] op);
    return op inside {OP_LDI, OP_STI};
  endfunction
endpackage

// File: rtl/lc3_mem_timeout.sv
// lc3_mem_timeout: per-access wait counter; expire flags the last allowed wait cycle
module lc3_mem_timeout #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expire = (MEM_TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/lc3_mem_seq.sv
// lc3_mem_seq: multi-cycle sequencer for LC-3 LD/ST/LDI/STI/LDR/STR/LEA
// Outputs are Moore decodes of state and captured opcode; only ld_mdr sees mem_ready.
module lc3_mem_seq
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        mem_ready,
  output logic        addr1_mux,
  output logic [1:0]  addr2_mux,
  output logic        ld_mar,
  output logic        mar_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic        ld_mdr,
  output logic        ld_reg,
  output logic        reg_src,
  output logic        ld_cc,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t state, nxt;
  logic [3:0] op_q;
  logic expire;
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[11:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) op_q <= ir[15:12];
    end
  lc3_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clr(state == ADDR || state == IMAR),
    .en((state == IRD || state == ACC) && !mem_ready),
    .expire(expire)
  );
  always_comb begin
    nxt       = state;
    ld_mar    = 1'b0;
    mar_sel   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    ld_mdr    = 1'b0;
    ld_reg    = 1'b0;
    reg_src   = 1'b0;
    ld_cc     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = state != IDLE;
    addr1_mux = (busy && is_legal(op_q)) ? (is_base(op_q) ? A1_SR1 : A1_PC) : A1_PC;
    addr2_mux = (busy && is_legal(op_q)) ? (is_base(op_q) ? A2_OFF6 : A2_OFF9) : A2_ZERO;
    case (state)
      IDLE: if (start) nxt = is_legal(ir[15:12]) ? ADDR : ERR;
      ADDR: begin
        ld_reg = op_q == OP_LEA;
        ld_mar = op_q != OP_LEA;
        nxt    = op_q == OP_LEA ? DONE : (is_ind(op_q) ? IRD : ACC);
      end
      IRD: begin
        mem_en = 1'b1;
        ld_mdr = mem_ready;
        nxt    = mem_ready ? IMAR : (expire ? ERR : IRD);
      end
      IMAR: begin
        ld_mar  = 1'b1;
        mar_sel = 1'b1;
        nxt     = ACC;
      end
      ACC: begin
        mem_en = 1'b1;
        mem_we = is_store(op_q);
        ld_mdr = mem_ready && !is_store(op_q);
        nxt    = mem_ready ? (is_store(op_q) ? DONE : WB) : (expire ? ERR : ACC);
      end
      WB: begin
        ld_reg  = 1'b1;
        reg_src = 1'b1;
        ld_cc   = 1'b1;
        nxt     = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      ERR: begin
        done = 1'b1;
        err  = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lc3_mem_seq.sv
// tb_lc3_mem_seq: vector table plus cycle-exact sequences, checked through a completion scoreboard
module tb_lc3_mem_seq;
  typedef struct {
    logic [15:0] ir;
    int dly;
    int lat;
    int err;
    int nreg;
    int nwe;
    int nmdr;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] ir = '0;
  logic mem_ready;
  logic addr1_mux, ld_mar, mar_sel, mem_en, mem_we, ld_mdr, ld_reg, reg_src, ld_cc, busy, done, err;
  logic [1:0] addr2_mux;
  logic [13:0] outs;
  logic [7:0] wcnt;
  int dly = 0;
  int nchk = 0;
  int nerr = 0;
  vec_t sb[$];
  vec_t vecs[$];
  logic [13:0] xs[$];
  bit act = 0;
  int cyc, nreg, nwe, nmdr;

  always #5 clk = ~clk;

  lc3_mem_seq #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .mem_ready(mem_ready),
    .addr1_mux(addr1_mux), .addr2_mux(addr2_mux), .ld_mar(ld_mar), .mar_sel(mar_sel),
    .mem_en(mem_en), .mem_we(mem_we), .ld_mdr(ld_mdr), .ld_reg(ld_reg), .reg_src(reg_src),
    .ld_cc(ld_cc), .busy(busy), .done(done), .err(err)
  );

  // {a1, a2, ld_mar mar_sel, mem_en mem_we ld_mdr, ld_reg reg_src ld_cc, busy done err}
  assign outs = {addr1_mux, addr2_mux, ld_mar, mar_sel, mem_en, mem_we, ld_mdr,
                 ld_reg, reg_src, ld_cc, busy, done, err};

  // memory answers after dly wait cycles of each access
  assign mem_ready = mem_en && (int'(wcnt) == dly);
  always @(posedge clk or posedge reset)
    if (reset) wcnt <= '0;
    else if (mem_en && !mem_ready) wcnt <= wcnt + 8'd1;
    else wcnt <= '0;

  task automatic chk(input string nm, input int act_v, input int exp_v);
    nchk++;
    if (act_v != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) act = 0;
    else if (start && !busy) begin
      act = 1; cyc = 0; nreg = 0; nwe = 0; nmdr = 0;
    end else if (act) begin
      cyc++;
      nreg += int'(ld_reg);
      nwe  += int'(mem_en && mem_we);
      nmdr += int'(ld_mdr);
      if (done) begin
        act = 0;
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          vec_t e;
          e = sb.pop_front();
          chk($sformatf("latency_%h", e.ir), cyc, e.lat);
          chk($sformatf("err_%h", e.ir), int'(err), e.err);
          chk($sformatf("ld_reg_cnt_%h", e.ir), nreg, e.nreg);
          chk($sformatf("we_cnt_%h", e.ir), nwe, e.nwe);
          chk($sformatf("ld_mdr_cnt_%h", e.ir), nmdr, e.nmdr);
        end
      end
    end else if (done) chk("stray_done", 1, 0);
  end

  task automatic start_op(input vec_t e, input bit push);
    @(posedge clk); #1;
    ir = e.ir; dly = e.dly; start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    chk("drain_timeout", 1, 0);
    sb.delete();
  endtask

  task automatic run_seq(input string nm, input vec_t e);
    start_op(e, 1);
    for (int k = 0; k < xs.size(); k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k + 1), int'(outs), int'(xs[k]));
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{16'hE005, 0, 2, 0, 1, 0, 0},
      '{16'h3205, 0, 3, 0, 0, 1, 0},
      '{16'h7283, 3, 6, 0, 0, 4, 0},
      '{16'h2205, 0, 4, 0, 1, 0, 1},
      '{16'h6283, 2, 6, 0, 1, 0, 1},
      '{16'hB403, 0, 5, 0, 0, 1, 1},
      '{16'hA403, 0, 6, 0, 1, 0, 2},
      '{16'hA403, 1, 8, 0, 1, 0, 2},
      '{16'hB403, 3, 11, 0, 0, 4, 1},
      '{16'h1042, 0, 1, 1, 0, 0, 0},
      '{16'hF025, 0, 1, 1, 0, 0, 0},
      '{16'h4800, 0, 1, 1, 0, 0, 0},
      '{16'h3205, 9, 6, 1, 0, 4, 0},
      '{16'h2205, 9, 6, 1, 0, 0, 0},
      '{16'hA403, 9, 6, 1, 0, 0, 0}
    };
    repeat (2) @(posedge clk);
    #1 chk("reset_outs", int'(outs), 0);
    reset = 1'b0;
    foreach (vecs[i]) begin
      start_op(vecs[i], 1);
      wait_idle();
    end
    xs = '{14'b0_10_10_000_000_100, 14'b0_10_00_101_000_100, 14'b0_10_00_000_111_100,
           14'b0_10_00_000_000_110, 14'b0_00_00_000_000_000};
    run_seq("ld", '{16'h2205, 0, 4, 0, 1, 0, 1});
    xs = '{14'b0_10_10_000_000_100, 14'b0_10_00_101_000_100, 14'b0_10_11_000_000_100,
           14'b0_10_00_101_000_100, 14'b0_10_00_000_111_100, 14'b0_10_00_000_000_110,
           14'b0_00_00_000_000_000};
    run_seq("ldi", '{16'hA403, 0, 6, 0, 1, 0, 2});
    xs = '{14'b1_01_10_000_000_100, 14'b1_01_00_110_000_100, 14'b1_01_00_110_000_100,
           14'b1_01_00_110_000_100, 14'b1_01_00_110_000_100, 14'b1_01_00_000_000_110,
           14'b0_00_00_000_000_000};
    run_seq("str", '{16'h7283, 3, 6, 0, 0, 4, 0});
    xs = '{14'b0_10_10_000_000_100, 14'b0_10_00_110_000_100, 14'b0_10_00_110_000_100,
           14'b0_10_00_110_000_100, 14'b0_10_00_110_000_100, 14'b0_10_00_000_000_111,
           14'b0_00_00_000_000_000};
    run_seq("st_timeout", '{16'h3205, 9, 6, 1, 0, 4, 0});
    xs = '{14'b0_00_00_000_000_111, 14'b0_00_00_000_000_000};
    run_seq("illegal", '{16'h1042, 0, 1, 1, 0, 0, 0});
    // a second start during a busy LD must be dropped
    start_op('{16'h2205, 2, 6, 0, 1, 0, 1}, 1);
    @(posedge clk); #1;
    ir = 16'h1042; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("busy_start_idle", int'(busy), 0);
    // reset in ACC aborts asynchronously
    start_op('{16'h3205, 9, 0, 0, 0, 0, 0}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_acc", int'(outs), int'(14'b0_10_00_110_000_100));
    #2 reset = 1'b1;
    #1 chk("reset_async", int'(outs), 0);
    @(negedge clk); #1;
    reset = 1'b0;
    xs = '{14'b0_10_00_000_100_100, 14'b0_10_00_000_000_110, 14'b0_00_00_000_000_000};
    run_seq("lea_after_reset", '{16'hE005, 0, 2, 0, 1, 0, 0});
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
